// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the M-extension issue/writeback controller:
// funct3 operation codes, FSM state encoding and the watchdog default.
package muldiv_ctrl_pkg;

    localparam int WDOG_MAX_DEF = 63;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of execute-stage, MULDIV-side and writeback signals around muldiv_ctrl.
// The controller uses the slave modport; the surrounding core uses master.
interface muldiv_ctrl_if;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic [31:0] md_rs1_o;
    logic [31:0] md_rs2_o;
    logic [2:0]  md_funct3_o;
    logic        md_start_o;
    logic [31:0] md_c_i;
    logic        md_busy_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i, md_c_i, md_busy_i,
        output md_rs1_o, md_rs2_o, md_funct3_o, md_start_o, stall_o,
        output wb_valid_o, wb_rd_o, wb_data_o, err_o
    );

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i, md_c_i, md_busy_i,
        input  md_rs1_o, md_rs2_o, md_funct3_o, md_start_o, stall_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, err_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences one M-extension instruction through an external MULDIV unit:
// latch operands, pulse start, wait on busy (with watchdog), write back.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WDOG_MAX = WDOG_MAX_DEF
) (
    input  logic         clk,
    input  logic         rstLow,
    muldiv_ctrl_if.slave bus
);

    state_e      state, state_nxt;
    logic [5:0]  wdog_cnt;
    logic [31:0] rs1_q, rs2_q, data_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        err_q;
    logic        accept, capture, abort;
    logic        stall, start, wb_valid;

    // rd=0 instructions retire as NOPs without ever touching MULDIV
    assign accept  = bus.valid_i && (bus.rd_i != 5'd0) && !bus.flush_i;
    assign capture = (state == S_WAIT) && !bus.md_busy_i && !bus.flush_i;
    assign abort   = (state == S_WAIT) && bus.md_busy_i && !bus.flush_i
                     && (wdog_cnt == 6'(WDOG_MAX));

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                stall = accept;
                if (accept) state_nxt = S_START;
            end
            S_START: begin
                stall = 1'b1;
                start = 1'b1;
                if (bus.flush_i) state_nxt = bus.md_busy_i ? S_DRAIN : S_IDLE;
                else             state_nxt = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (bus.flush_i)         state_nxt = bus.md_busy_i ? S_DRAIN : S_IDLE;
                else if (!bus.md_busy_i) state_nxt = S_DONE;
                else if (abort)          state_nxt = S_DRAIN;
            end
            S_DONE: begin
                // valid_i here belongs to the retiring instruction, so it is not looked at
                wb_valid  = !bus.flush_i;
                state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (!bus.md_busy_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!rstLow) begin
            stall    = 1'b0;
            start    = 1'b0;
            wb_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstLow) begin
            state    <= S_IDLE;
            wdog_cnt <= 6'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= abort;
            if (state == S_IDLE && accept) begin
                rs1_q    <= bus.rs1_i;
                rs2_q    <= bus.rs2_i;
                funct3_q <= bus.funct3_i;
                rd_q     <= bus.rd_i;
            end
            // Counter restarts on every START->WAIT entry and saturates at all-ones
            if (state == S_START)
                wdog_cnt <= 6'd0;
            else if (state == S_WAIT && wdog_cnt != 6'h3F)
                wdog_cnt <= wdog_cnt + 6'd1;
            if (capture) data_q <= bus.md_c_i;
        end
    end

    assign bus.md_rs1_o    = rs1_q;
    assign bus.md_rs2_o    = rs2_q;
    assign bus.md_funct3_o = funct3_q;
    assign bus.md_start_o  = start;
    assign bus.stall_o     = stall;
    assign bus.wb_valid_o  = wb_valid;
    assign bus.wb_rd_o     = rd_q;
    assign bus.wb_data_o   = data_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl: per-transaction timelines are planned from
// the operation's MULDIV latency and flush point, then compared every cycle.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int NCYC = 32768;
    localparam int WD   = 63;

    logic clk = 1'b0;
    logic rstLow;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();
    muldiv_ctrl #(.WDOG_MAX(WD)) dut (.clk(clk), .rstLow(rstLow), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    bit          chk[NCYC];
    bit          e_stall[NCYC], e_start[NCYC], e_wbv[NCYC], e_err[NCYC], e_md[NCYC];
    logic [4:0]  e_rd[NCYC];
    logic [2:0]  e_f3[NCYC];
    logic [31:0] e_data[NCYC], e_rs1[NCYC], e_rs2[NCYC];

    int          last_wb_cyc = -1;
    logic [31:0] last_wb_data = 32'd0;
    logic [4:0]  last_wb_rd = 5'd0;
    int          err_seen = 0;
    int          last_err_cyc = -1;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, ub;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (op)
            F3_MUL:    begin p = 64'(sa * sb); r = p[31:0]; end
            F3_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
            F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            F3_DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                           (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    r = (b == 0) ? a :
                           (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic void clear_exp(input int c);
        if (c < NCYC) begin
            chk[c] = 1'b1; e_stall[c] = 1'b0; e_start[c] = 1'b0; e_wbv[c] = 1'b0;
            e_err[c] = 1'b0; e_md[c] = 1'b0; e_rd[c] = 5'd0; e_f3[c] = 3'd0;
            e_data[c] = 32'd0; e_rs1[c] = 32'd0; e_rs2[c] = 32'd0;
        end
    endfunction

    always @(negedge clk) begin
        if (bus.wb_valid_o === 1'b1) begin
            last_wb_cyc = cyc; last_wb_data = bus.wb_data_o; last_wb_rd = bus.wb_rd_o;
        end
        if (bus.err_o === 1'b1) begin
            err_seen++; last_err_cyc = cyc;
        end
        if (cyc < NCYC && chk[cyc]) begin
            check1("stall_o", 32'(bus.stall_o), 32'(e_stall[cyc]));
            check1("md_start_o", 32'(bus.md_start_o), 32'(e_start[cyc]));
            check1("wb_valid_o", 32'(bus.wb_valid_o), 32'(e_wbv[cyc]));
            check1("err_o", 32'(bus.err_o), 32'(e_err[cyc]));
            if (e_wbv[cyc]) begin
                check1("wb_rd_o", 32'(bus.wb_rd_o), 32'(e_rd[cyc]));
                check1("wb_data_o", bus.wb_data_o, e_data[cyc]);
            end
            if (e_md[cyc]) begin
                check1("md_rs1_o", bus.md_rs1_o, e_rs1[cyc]);
                check1("md_rs2_o", bus.md_rs2_o, e_rs2[cyc]);
                check1("md_funct3_o", 32'(bus.md_funct3_o), 32'(e_f3[cyc]));
            end
        end
    end

    task automatic drive(input bit v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit fl, input bit busy, input logic [31:0] c,
                         input bit rst);
        @(posedge clk);
        #1;
        bus.valid_i = v; bus.funct3_i = f3; bus.rs1_i = a; bus.rs2_i = b; bus.rd_i = rd;
        bus.flush_i = fl; bus.md_busy_i = busy; bus.md_c_i = c; rstLow = !rst;
    endtask

    // L = cycles MULDIV stays busy after the start cycle; f = cycle offset of a
    // one-cycle flush relative to the request (negative means none).
    task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int L, input int f, input int gap,
                           output int t0);
        logic [31:0] res;
        bit acc, fl_eff, wd, normal, v;
        int cap, end_k, span, last_busy, c;
        res       = ref_md(op, a, b);
        acc       = (rd != 5'd0) && (f != 0);
        cap       = 2 + L;
        fl_eff    = acc && f >= 1 && f <= cap && !(L >= WD + 1 && f > WD + 2);
        wd        = acc && !fl_eff && L >= WD + 1;
        normal    = acc && !fl_eff && !wd;
        if (!acc)        end_k = 0;
        else if (fl_eff) end_k = (f >= 2 && f <= 1 + L) ? cap : f;
        else if (wd)     end_k = cap;
        else             end_k = cap + 1;
        last_busy = acc ? 1 + L : 0;
        span      = ((end_k > last_busy) ? end_k : last_busy) + gap;
        t0        = cyc + 1;
        for (int k = 0; k <= span; k++) begin
            c = t0 + k;
            clear_exp(c);
            if (c < NCYC) begin
                e_stall[c] = acc && k <= end_k && !(normal && k == end_k);
                e_start[c] = acc && k == 1;
                e_wbv[c]   = normal && k == end_k && f != end_k;
                e_err[c]   = wd && k == WD + 3;
                e_md[c]    = acc && k >= 1 && k <= end_k;
                e_rd[c] = rd; e_data[c] = res; e_rs1[c] = a; e_rs2[c] = b; e_f3[c] = op;
            end
        end
        for (int k = 0; k <= span; k++) begin
            v = (k == 0) ? 1'b1 : ((acc && k <= end_k) ? 1'($urandom) : 1'b0);
            if (k == 0)
                drive(v, op, a, b, rd, (k == f), 1'b0, $urandom, 1'b0);
            else
                drive(v, 3'($urandom), $urandom, $urandom, 5'($urandom), (k == f),
                      acc && k >= 2 && k <= last_busy, (k == cap) ? res : $urandom, 1'b0);
        end
    endtask

    initial begin
        int t0, prev_wb, prev_err, L, f;
        logic [2:0] op;
        logic [31:0] a, b;
        logic [4:0] rd;
        bit special;
        rstLow = 1'b0;
        bus.valid_i = 0; bus.funct3_i = 0; bus.rs1_i = 0; bus.rs2_i = 0; bus.rd_i = 0;
        bus.flush_i = 0; bus.md_busy_i = 0; bus.md_c_i = 0;

        // Reference model pinned against hand-computed results
        check1("ref_mul", ref_md(F3_MUL, 32'd7, 32'd6), 32'h0000_002A);
        check1("ref_divu", ref_md(F3_DIVU, 32'd100, 32'd7), 32'h0000_000E);
        check1("ref_div0", ref_md(F3_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
        check1("ref_divovf", ref_md(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check1("ref_removf", ref_md(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
        check1("ref_mulhu", ref_md(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check1("ref_rem", ref_md(F3_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        // Reset state, with stimulus that would otherwise start an operation
        drive(1'b1, F3_MUL, 32'd3, 32'd4, 5'd9, 1'b0, 1'b0, 32'h1234, 1'b1);
        drive(1'b1, F3_MUL, 32'd3, 32'd4, 5'd9, 1'b0, 1'b0, 32'h1234, 1'b1);
        @(negedge clk);
        check1("rst_stall", 32'(bus.stall_o), 32'd0);
        check1("rst_start", 32'(bus.md_start_o), 32'd0);
        check1("rst_wbv", 32'(bus.wb_valid_o), 32'd0);
        check1("rst_err", 32'(bus.err_o), 32'd0);
        check1("rst_wb_rd", 32'(bus.wb_rd_o), 32'd0);
        check1("rst_wb_data", bus.wb_data_o, 32'd0);
        check1("rst_md_rs1", bus.md_rs1_o, 32'd0);
        check1("rst_md_rs2", bus.md_rs2_o, 32'd0);
        check1("rst_md_f3", 32'(bus.md_funct3_o), 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Directed: minimum-latency MUL
        run_txn(F3_MUL, 32'd7, 32'd6, 5'd5, 0, -1, 2, t0);
        check1("mul_wb_cycle", 32'(last_wb_cyc), 32'(t0 + 3));
        check1("mul_wb_data", last_wb_data, 32'h0000_002A);
        check1("mul_wb_rd", 32'(last_wb_rd), 32'd5);

        // Directed: DIVU with a busy period
        run_txn(F3_DIVU, 32'd100, 32'd7, 5'd3, 6, -1, 2, t0);
        check1("divu_wb_cycle", 32'(last_wb_cyc), 32'(t0 + 9));
        check1("divu_wb_data", last_wb_data, 32'h0000_000E);

        // Directed: divide-by-zero and signed overflow pass through
        run_txn(F3_DIV, 32'd1234, 32'd0, 5'd4, 0, -1, 1, t0);
        check1("div0_wb_data", last_wb_data, 32'hFFFF_FFFF);
        run_txn(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, -1, 1, t0);
        check1("divovf_wb_data", last_wb_data, 32'h8000_0000);

        // Directed: flush in the third WAIT cycle, then a normal request
        prev_wb = last_wb_cyc;
        run_txn(F3_DIVU, 32'd100, 32'd7, 5'd3, 8, 4, 2, t0);
        check1("flush_no_wb", 32'(last_wb_cyc), 32'(prev_wb));
        run_txn(F3_MUL, 32'd9, 32'd9, 5'd10, 0, -1, 1, t0);
        check1("after_flush_wb", last_wb_data, 32'd81);

        // Directed: rd=0 is a NOP
        prev_wb = last_wb_cyc;
        run_txn(F3_MUL, 32'd2, 32'd2, 5'd0, 0, -1, 2, t0);
        check1("nop_no_wb", 32'(last_wb_cyc), 32'(prev_wb));

        // Directed: watchdog boundary (63 busy cycles completes, 64 and 70 abort)
        prev_err = err_seen;
        run_txn(F3_DIVU, 32'd50, 32'd5, 5'd7, WD, -1, 2, t0);
        check1("wdog63_wb_data", last_wb_data, 32'd10);
        check1("wdog63_no_err", 32'(err_seen), 32'(prev_err));
        prev_wb = last_wb_cyc;
        run_txn(F3_DIVU, 32'd50, 32'd5, 5'd7, 70, -1, 2, t0);
        check1("wdog70_err_cnt", 32'(err_seen), 32'(prev_err + 1));
        check1("wdog70_err_cycle", 32'(last_err_cyc), 32'(t0 + 66));
        check1("wdog70_no_wb", 32'(last_wb_cyc), 32'(prev_wb));
        run_txn(F3_REMU, 32'd50, 32'd7, 5'd8, WD + 1, -1, 2, t0);
        check1("wdog64_err_cnt", 32'(err_seen), 32'(prev_err + 2));

        // Directed: flush during DONE suppresses writeback
        prev_wb = last_wb_cyc;
        run_txn(F3_MUL, 32'd3, 32'd5, 5'd11, 0, 3, 2, t0);
        check1("done_flush_no_wb", 32'(last_wb_cyc), 32'(prev_wb));

        // Directed: reset in the middle of a busy DIVU
        t0 = cyc + 1;
        for (int k = 0; k <= 12; k++) clear_exp(t0 + k);
        e_stall[t0] = 1;
        e_stall[t0 + 1] = 1; e_start[t0 + 1] = 1;
        e_stall[t0 + 2] = 1; e_stall[t0 + 3] = 1;
        for (int k = 1; k <= 3; k++) begin
            e_md[t0 + k] = 1; e_rs1[t0 + k] = 32'd100; e_rs2[t0 + k] = 32'd7; e_f3[t0 + k] = F3_DIVU;
        end
        chk[t0 + 4] = 1'b0;
        e_md[t0 + 5] = 1;
        prev_wb = last_wb_cyc;
        for (int k = 0; k <= 12; k++) begin
            drive(k == 0, F3_DIVU, 32'd100, 32'd7, 5'd3, 1'b0, k >= 2 && k <= 9, 32'h0000_000E, k == 4);
            if (k == 5) begin
                @(negedge clk);
                check1("midrst_wb_data", bus.wb_data_o, 32'd0);
                check1("midrst_wb_rd", 32'(bus.wb_rd_o), 32'd0);
            end
        end
        check1("midrst_no_wb", 32'(last_wb_cyc), 32'(prev_wb));

        // Randomized transactions
        for (int n = 0; n < 250; n++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = ($urandom % 8 == 0) ? 32'd0 : (($urandom % 2) ? $urandom : 32'($urandom % 200));
            if (op == F3_DIV || op == F3_REM)
                if ($urandom % 10 == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            special = (b == 0) || ((op == F3_DIV || op == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            L  = (op < 3'd4 || special) ? 0 : $urandom_range(1, 8);
            f  = ($urandom % 10 < 7) ? -1 : $urandom_range(0, 3 + L);
            run_txn(op, a, b, rd, L, f, $urandom_range(1, 3), t0);
        end

        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 63, meaning the maximum number of WAIT cycles before the watchdog aborts.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstLow, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1, execute stage presents an M-extension instruction.
REQ-005 SHALL have port funct3_i, input, 3, the M operation code (MUL..REMU, 0..7).
REQ-006 SHALL have ports rs1_i and rs2_i, input, 32 each, the operand values.
REQ-007 SHALL have port rd_i, input, 5, the destination register index.
REQ-008 SHALL have port flush_i, input, 1, pipeline flush; kills the in-flight operation.
REQ-009 SHALL have ports md_rs1_o, md_rs2_o (output, 32) and md_funct3_o (output, 3), the registered operands and op driven to the MULDIV unit.
REQ-010 SHALL have port md_start_o, output, 1, one-cycle start pulse to MULDIV.
REQ-011 SHALL have ports md_c_i (input, 32) and md_busy_i (input, 1), the MULDIV result and busy flag.
REQ-012 SHALL have port stall_o, output, 1, holds the upstream pipeline.
REQ-013 SHALL have ports wb_valid_o (output, 1), wb_rd_o (output, 5) and wb_data_o (output, 32), the registered writeback.
REQ-014 SHALL have port err_o, output, 1, one-cycle watchdog-abort pulse.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, DONE, DRAIN.
REQ-016 IDLE: when valid_i=1, rd_i!=0 and flush_i=0, SHALL latch rs1_i/rs2_i/funct3_i/rd_i, assert stall_o combinationally in the same cycle, and go to START.
REQ-017 IDLE with rd_i=0: SHALL treat the instruction as a NOP -- no start, no stall, no writeback.
REQ-018 START: SHALL assert md_start_o for exactly this one cycle, then go to WAIT.
REQ-019 md_rs1_o, md_rs2_o and md_funct3_o SHALL hold their latched values from START until the FSM leaves WAIT/DRAIN.
REQ-020 WAIT: in the first cycle with md_busy_i=0, SHALL capture md_c_i into wb_data_o and go to DONE; otherwise remain in WAIT.
REQ-021 DONE: SHALL pulse wb_valid_o for one cycle with wb_rd_o = latched rd, deassert stall_o, then return to IDLE.
REQ-022 DONE: valid_i SHALL be ignored in this cycle, because it is the instruction now retiring.
REQ-023 stall_o SHALL be 1 in START, WAIT and DRAIN, and 0 in DONE.
REQ-024 Minimum latency (non-busy op, i.e. MUL or a special-case DIV): request in IDLE at cycle 0, md_start_o at cycle 1, capture at cycle 2, wb_valid_o at cycle 3.
REQ-025 flush_i in START or WAIT: SHALL suppress writeback; go to DRAIN if md_busy_i=1, else to IDLE.
REQ-026 DRAIN: SHALL stay while md_busy_i=1, go to IDLE when it is 0, and never assert wb_valid_o.
REQ-027 flush_i in DONE: SHALL suppress wb_valid_o and return to IDLE.
REQ-028 A 6-bit WAIT cycle counter SHALL be cleared on entering WAIT; when it reaches WDOG_MAX with md_busy_i=1, the block SHALL pulse err_o and go to DRAIN with no writeback.
REQ-029 The block SHALL NOT modify the result; divide-by-zero and overflow values are passed through from MULDIV unchanged.

Reset
REQ-030 When rstLow=0 at a clock edge, the FSM SHALL go to IDLE and the block SHALL clear wb_valid_o, md_start_o, stall_o, err_o, wb_rd_o, wb_data_o, all md_* operand outputs and the watchdog counter.
REQ-031 Reset mid-operation SHALL abandon the operation with no writeback; a MULDIV still busy afterwards SHALL be ignored until IDLE accepts a new request.

Structure
REQ-032 A shared package SHALL hold the funct3 constants (MUL=0 .. REMU=7), the FSM state encoding and the WDOG_MAX default.
REQ-033 The block SHALL be a single module with no sub-modules; MULDIV SHALL be instantiated beside it by the core, not inside it.

Verification
REQ-034 MUL, rs1=7, rs2=6, rd=5 -> one md_start_o pulse; wb_valid_o with wb_rd_o=5 and wb_data_o=0x0000002A at cycle 3.
REQ-035 DIVU, rs1=100, rs2=7, rd=3 -> stall_o held through the busy period; wb_data_o=0x0000000E one cycle after md_busy_i falls.
REQ-036 DIV, rs2=0 -> wb_data_o=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> wb_data_o=0x80000000.
REQ-037 DIVU started, flush_i pulsed in the 3rd WAIT cycle -> DRAIN until md_busy_i=0; no wb_valid_o; next request accepted normally.
REQ-038 rd_i=0 with valid_i=1 -> no md_start_o, stall_o=0, no wb_valid_o.
REQ-039 md_busy_i forced high for 70 cycles -> err_o pulse after 63 WAIT cycles; FSM in DRAIN; no wb_valid_o.
